instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: DW, 16, instruction and immediate word width.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: run  in  1  start request, sampled only in IDLE.
REQ-005 Port: instr  in  DW  instruction word: [15:13] opcode, [12:10] X, [9:7] Y, [6:0] ignored.
REQ-006 Port: data_out  out  1  enables the immediate-data tri-state driver onto bus1.
REQ-007 Port: bus2_buf_en  out  8  one-hot register-to-bus1 driver enable; bit 7 = R0, bit 0 = R7.
REQ-008 Port: reg_en  out  8  one-hot register load enable; bit 7 = R0, bit 0 = R7.
REQ-009 Port: a_in  out  1  load enable for register A.
REQ-010 Port: g_in  out  1  load enable for register G.
REQ-011 Port: g_out  out  1  enables the G tri-state driver onto bus1.
REQ-012 Port: math_enables  out  2  ALU op: 00 add, 01 sub, 10 and, 11 reserved.
REQ-013 Port: done  out  1  one-cycle pulse in the final cycle of every instruction.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: illegal  out  1  one-cycle pulse, coincident with done, for an undefined opcode.

Function
REQ-016 States: IDLE, T1, T2, T3; Moore outputs decoded from the state and the latched IR.
REQ-017 IDLE: if run=1, IR <= instr and next state is T1; otherwise stay in IDLE; all enables 0.
REQ-018 Opcodes: 000 mv (Rx<-Ry), 001 mvi (Rx<-immediate), 010 add, 011 sub, 100 and (Rx<-Rx op Ry); 101-111 illegal.
REQ-019 T1 mv: bus2_buf_en[Y]=1, reg_en[X]=1, done=1; next state IDLE.
REQ-020 T1 mvi: data_out=1, reg_en[X]=1, done=1; next state IDLE.
REQ-021 T1 ALU op: bus2_buf_en[X]=1, a_in=1; next state T2.
REQ-022 T2 ALU op: bus2_buf_en[Y]=1, g_in=1, math_enables per opcode; next state T3.
REQ-023 T3 ALU op: g_out=1, reg_en[X]=1, done=1; next state IDLE.
REQ-024 T1 illegal: done=1, illegal=1, all enables 0; next state IDLE.
REQ-025 Latency from run sampled high to done: mv/mvi/illegal 2 cycles; ALU ops 4 cycles.
REQ-026 At most one of data_out, g_out, bus2_buf_en[*] SHALL be high in any cycle.
REQ-027 math_enables SHALL be 00 in every cycle other than T2.
REQ-028 run and instr SHALL be ignored while busy=1; IR changes only on the IDLE-to-T1 transition.
REQ-029 X=Y SHALL be legal (e.g. add R3,R3 doubles R3); the same bit is used in T1 and T2.
REQ-030 run held high causes back-to-back instructions: the cycle after done is IDLE, which samples run again.

Reset
REQ-031 While rst=1: state=IDLE, IR=0, and all outputs 0, independent of clk.
REQ-032 Reset asserted mid-instruction SHALL abort immediately with no further enables and no done pulse.
REQ-033 The first run sample occurs on the first rising clk edge after rst deasserts.

Structure
REQ-034 The opcode constants, state encoding and math_enables codes SHALL live in a shared package, seq_pkg.
REQ-035 A single sub-module, onehot_dec3 (a combinational 3-to-8 decoder, bit 7 for index 0), SHALL be instantiated for the X and Y decodes.
REQ-036 The block contains no datapath registers other than IR and the state register.

Verification
REQ-037 Case: rst mid-T2 of add -> all outputs are 0 asynchronously, no done, and busy stays 0 until the next run.
REQ-038 Case: instr=16'h2000 (mvi R0), run pulse -> next cycle data_out=1, reg_en=8'h80, done=1; then IDLE.
REQ-039 Case: instr=16'h4480 (add R1,R1) -> T1 bus2_buf_en=8'h40 and a_in=1; T2 bus2_buf_en=8'h40, g_in=1, math_enables=00; T3 g_out=1, reg_en=8'h40, done=1.
REQ-040 Case: instr=16'h6E80 (sub R3,R5) -> T2 math_enables=01 and bus2_buf_en=8'h04; T3 reg_en=8'h10.
REQ-041 Case: instr=16'hE000 -> done=1 and illegal=1 in T1; reg_en, bus2_buf_en, a_in, g_in and g_out stay 0.
REQ-042 Case: run held high with instr changed during busy -> the new value is taken only at IDLE; bus-driver one-hot assertion (REQ-026) holds for the whole run.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared opcodes, state encoding and ALU codes for instr_sequencer
package seq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;
   localparam logic [2:0] OP_MV = 3'd0, OP_MVI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3, OP_AND = 3'd4;
   localparam logic [1:0] MATH_ADD = 2'b00, MATH_SUB = 2'b01, MATH_AND = 2'b10;
   function automatic logic is_alu(input logic [2:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND};
   endfunction
   function automatic logic [1:0] math_code(input logic [2:0] op);
      return op == OP_SUB ? MATH_SUB : op == OP_AND ? MATH_AND : MATH_ADD;
   endfunction
endpackage

// File: rtl/onehot_dec3.sv
// onehot_dec3: 3-to-8 one-hot decoder, index 0 maps to bit 7
module onehot_dec3 (
   input  logic [2:0] idx,
   output logic [7:0] oh
);
   assign oh = 8'h80 >> idx;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer driving register/bus enables from a latched instruction
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic [DW-1:0] instr,
   output logic          data_out,
   output logic [7:0]    bus2_buf_en,
   output logic [7:0]    reg_en,
   output logic          a_in,
   output logic          g_in,
   output logic          g_out,
   output logic [1:0]    math_enables,
   output logic          done,
   output logic          busy,
   output logic          illegal
);
   state_t        state, state_nx;
   logic [DW-1:0] ir;
   logic [7:0]    x_oh, y_oh;
   logic [2:0]    op;
   logic          alu;
   logic          unused_ir;
   assign op        = ir[15:13];
   assign alu       = is_alu(op);
   assign unused_ir = ^ir[6:0];
   onehot_dec3 u_dec_x (.idx(ir[12:10]), .oh(x_oh));
   onehot_dec3 u_dec_y (.idx(ir[9:7]),   .oh(y_oh));
   // state register; IR loads only when a run is accepted in IDLE
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         ir    <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && run) ir <= instr;
      end
   // next state: ALU ops take T1..T3, everything else finishes in T1
   always_comb
      case (state)
         S_IDLE:  state_nx = run ? S_T1 : S_IDLE;
         S_T1:    state_nx = alu ? S_T2 : S_IDLE;
         S_T2:    state_nx = S_T3;
         default: state_nx = S_IDLE;
      endcase
   // Moore outputs from state and IR; IDLE (and reset) drives everything low
   always_comb begin
      data_out     = 1'b0;
      bus2_buf_en  = '0;
      reg_en       = '0;
      a_in         = 1'b0;
      g_in         = 1'b0;
      g_out        = 1'b0;
      math_enables = MATH_ADD;
      done         = 1'b0;
      illegal      = 1'b0;
      case (state)
         S_T1:
            if (alu) begin
               bus2_buf_en = x_oh;
               a_in        = 1'b1;
            end else if (op == OP_MV) begin
               bus2_buf_en = y_oh;
               reg_en      = x_oh;
               done        = 1'b1;
            end else if (op == OP_MVI) begin
               data_out = 1'b1;
               reg_en   = x_oh;
               done     = 1'b1;
            end else begin
               done    = 1'b1;
               illegal = 1'b1;
            end
         S_T2: begin
            bus2_buf_en  = y_oh;
            g_in         = 1'b1;
            math_enables = math_code(op);
         end
         S_T3: begin
            g_out  = 1'b1;
            reg_en = x_oh;
            done   = 1'b1;
         end
         default: ;
      endcase
   end
   assign busy = state != S_IDLE;
endmodule
